branch_pred_ctrl: RTL and testbench
===================================

# branch_pred_ctrl

Branch-prediction controller for the MicroEV20 fetch/microsequencer path. Keeps a table of 2-bit saturating counters that supplies taken/not-taken predictions for JNE, and queues each issued prediction until the JNE checker resolves it. On a checker result it trains the table. On a mispredict it squashes younger predictions and runs a flush/redirect sequence for the fetch unit.

## Interface
- IDX_W, 4: BHT index width. The table has 2^IDX_W counters, indexed by pred_pc[IDX_W-1:0].
- PC_W, 16: program-counter width.
- FLUSH_CYC, 2: number of cycles flush is held high after a mispredict (valid range 1..7).

- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pred_req  in  1  fetch has decoded a branch this cycle.
- pred_pc  in  PC_W  address of that branch.
- pred_target  in  PC_W  branch target address.
- pred_type  in  2  branch type: 00 none, 01 JMP (unconditional), 10 JNE, 11 reserved.
- pred_taken  out  1  combinational prediction for the current request.
- pred_ack  out  1  combinational; the request is accepted and pushed this cycle.
- last_pred  out  1  registered prediction of the most recently accepted branch (checker aux_last_pred).
- last_type  out  2  registered type of the most recently accepted branch (checker aux_pred_type).
- chk_checked  in  1  checker "checked" level.
- chk_incorrect  in  1  checker incorrect_pred.
- chk_correct  in  1  checker correct_pred, i.e. the actual direction (1 = taken).
- flush  out  1  squash in-flight fetch.
- redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  PC_W  corrected fetch address.
- pend_cnt  out  2  number of pending unresolved predictions (0..2).
- err  out  1  sticky; set when a check event arrives with the queue empty.

## Operation
- **BHT.** Counters reset to 2'b01 (weakly not-taken).
- **Prediction.**
  - JNE: pred_taken = counter[idx][1].
  - JMP: pred_taken = 1; the BHT is not read.
  - Type 00/11: pred_taken = 0 and pred_ack = 0.
- **Acceptance.** pred_ack = pred_req & type∈{01,10} & state==IDLE & pend_cnt<2 & !(chk_evt & chk_incorrect).
- **On ack:**
  - Push {idx, pred_pc, pred_target, pred_taken, type} into a 2-entry FIFO.
  - last_pred <= pred_taken and last_type <= pred_type.
- **Check event.** chk_evt = chk_checked & !chk_checked_q, a rising-edge detect. The checker holds "checked" for a whole microstep; that multi-cycle level counts as exactly one event.
- **On chk_evt with queue non-empty:**
  - Pop the head.
  - For a JNE head: increment the counter if chk_correct=1, otherwise decrement, saturating at 00 and 11.
  - For a JMP head: no counter update.
- **On chk_evt with queue empty:** no pop, no update; err <= 1. err clears only on reset.
- **Simultaneous push and pop:** both happen and pend_cnt is unchanged. The pushed entry lands behind the popped head.
- **Mispredict** (chk_evt & chk_incorrect & queue non-empty):
  - Train the head counter as above.
  - Clear the entire FIFO, discarding younger entries without training.
  - Latch redirect_pc = chk_correct ? head.target : head.pc+1, computed modulo 2^PC_W so 16'hFFFF+1 = 0.
  - Go to FLUSH.
- **State machine:**
  - IDLE: normal operation.
  - FLUSH: flush=1; a counter runs FLUSH_CYC cycles, then the FSM moves to REDIR.
  - REDIR: redirect_valid=1 for one cycle, then IDLE.
- **During FLUSH/REDIR:**
  - pred_ack=0.
  - Check events are ignored: no pop, no training, no err, because the queue is empty by construction.
  - The edge detector keeps tracking.
- **Table hazard.** A counter updated and read in the same cycle gives the pre-update value; there is no bypass.
- **Reset mid-sequence:** rst_n low immediately returns the FSM to IDLE, empties the FIFO, re-initialises every counter to 01, and clears all registered outputs.

## Timing
- **Reset values:** last_pred 0, last_type 00, flush 0, redirect_valid 0, redirect_pc 0, pend_cnt 0, err 0, chk_checked_q 0, FSM IDLE.
- **Same cycle as the request:** pred_taken and pred_ack are valid combinationally.
- **One cycle after ack:** last_pred, last_type and pend_cnt reflect the push.
- **Training:** the counter takes its new value at the edge that samples chk_evt.
- **Mispredict timeline:** with the event sampled at edge E:
  - flush is high from E through E+FLUSH_CYC-1, i.e. FLUSH_CYC cycles.
  - redirect_valid is high during the cycle after that.
  - pred_ack can next assert the cycle after REDIR.
  - Total turnaround is FLUSH_CYC+1 cycles.
- **Outputs:** flush, redirect_valid and redirect_pc are registered. pred_taken and pred_ack are combinational only.

## Test plan
- **Reset and prediction:** release reset, then JNE at pc=16'h0013 → pred_taken=0, pred_ack=1; next cycle last_pred=0, last_type=10, pend_cnt=1.
- **Training and check-level edge detect:** accept JNE pc=16'h0013, then pulse chk_checked for 3 cycles with chk_correct=1, chk_incorrect=0 → exactly one pop (pend_cnt 1→0) and counter[3] 01→10. The next JNE at pc=16'h0003 predicts taken.
- **Mispredict and redirect:** with FLUSH_CYC=2, accept JNE pc=16'h0020, target=16'h0040, predicted 0, then a second branch (pend_cnt=2). Check event with incorrect=1, correct=1 → FIFO cleared, flush high for 2 cycles, then redirect_valid for 1 cycle with redirect_pc=16'h0040. pred_ack stays 0 throughout.
- **Full queue and saturation:** with 2 entries pending, a third pred_req gives pred_ack=0 and pend_cnt stays 2. Driving 4 taken-resolutions on one index leaves the counter at 11, not wrapped.
- **Simultaneous events and err:** a push and a non-mispredict check event in the same cycle leave pend_cnt unchanged and keep entry order. A check event with an empty queue sets err=1, which stays set until rst_n.
- **Reset mid-FLUSH:** assert rst_n low during FLUSH → flush=0 and redirect_valid=0 immediately. After release, counter[any] is back to 01 and pend_cnt=0.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
// JNE/JMP branch predictor: 2-bit counter table, 2-entry pending-prediction queue,
// checker-driven training and a flush/redirect sequence on mispredict.
module branch_pred_ctrl #(
  parameter int IDX_W     = 4,
  parameter int PC_W      = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_req,
  input  logic [PC_W-1:0] pred_pc,
  input  logic [PC_W-1:0] pred_target,
  input  logic [1:0]      pred_type,
  output logic            pred_taken,
  output logic            pred_ack,
  output logic            last_pred,
  output logic [1:0]      last_type,
  input  logic            chk_checked,
  input  logic            chk_incorrect,
  input  logic            chk_correct,
  output logic            flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic [1:0]      pend_cnt,
  output logic            err
);
  localparam int         DEPTH = 1 << IDX_W;
  localparam logic [1:0] T_JMP = 2'b01;
  localparam logic [1:0] T_JNE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  target;
    logic             taken;
    logic [1:0]       btype;
  } entry_t;

  state_e            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  entry_t            fifo_q [2];
  entry_t            fifo_d [2];
  entry_t            new_entry;
  logic [1:0]        cnt_q, cnt_d;
  logic              chk_q;
  logic              flush_q, redir_v_q, err_q, last_pred_q;
  logic [1:0]        last_type_q;
  logic [PC_W-1:0]   redir_pc_q;
  logic [2*DEPTH-1:0] bht_vec;
  logic [IDX_W-1:0]  req_idx;
  logic              is_idle, chk_evt, pop, mispred, train_en;

  assign req_idx = pred_pc[IDX_W-1:0];
  assign is_idle = (state_q == S_IDLE);
  // The checker holds "checked" for a whole microstep; only its rising edge is an event.
  assign chk_evt = chk_checked & ~chk_q;
  assign pop     = is_idle & chk_evt & (cnt_q != 2'd0);
  assign mispred = pop & chk_incorrect;
  assign train_en = pop & (fifo_q[0].btype == T_JNE);

  always_comb begin
    case (pred_type)
      T_JNE:   pred_taken = bht_vec[{req_idx, 1'b1}];
      T_JMP:   pred_taken = 1'b1;
      default: pred_taken = 1'b0;
    endcase
  end

  assign pred_ack = pred_req & ((pred_type == T_JMP) | (pred_type == T_JNE)) & is_idle &
                    (cnt_q < 2'd2) & ~(chk_evt & chk_incorrect);

  // Counter table; reads see the pre-update value when trained in the same cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bht
      logic [1:0] ctr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctr_q <= 2'b01;
        end else if (train_en && (fifo_q[0].idx == IDX_W'(gi))) begin
          if (chk_correct) begin
            if (ctr_q != 2'b11) ctr_q <= ctr_q + 2'd1;
          end else begin
            if (ctr_q != 2'b00) ctr_q <= ctr_q - 2'd1;
          end
        end
      end
      assign bht_vec[2*gi +: 2] = ctr_q;
    end
  endgenerate

  // Head always sits in slot 0; a pop shifts slot 1 forward before any push lands.
  always_comb begin
    new_entry.idx    = req_idx;
    new_entry.pc     = pred_pc;
    new_entry.target = pred_target;
    new_entry.taken  = pred_taken;
    new_entry.btype  = pred_type;
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (mispred) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        fifo_d[0] = fifo_q[1];
        cnt_d     = cnt_q - 2'd1;
      end
      if (pred_ack) begin
        fifo_d[cnt_d[0]] = new_entry;
        cnt_d            = cnt_d + 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (mispred) begin
          state_d = S_FLUSH;
          fcnt_d  = 3'(FLUSH_CYC - 1);
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 3'd0) state_d = S_REDIR;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fcnt_q      <= 3'd0;
      cnt_q       <= 2'd0;
      chk_q       <= 1'b0;
      flush_q     <= 1'b0;
      redir_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      err_q       <= 1'b0;
      last_pred_q <= 1'b0;
      last_type_q <= 2'b00;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
      chk_q     <= chk_checked;
      flush_q   <= (state_d == S_FLUSH);
      redir_v_q <= (state_d == S_REDIR);
      if (mispred)
        redir_pc_q <= chk_correct ? fifo_q[0].target : fifo_q[0].pc + PC_W'(1);
      if (is_idle && chk_evt && (cnt_q == 2'd0))
        err_q <= 1'b1;
      if (pred_ack) begin
        last_pred_q <= pred_taken;
        last_type_q <= pred_type;
      end
    end
  end

  assign last_pred      = last_pred_q;
  assign last_type      = last_type_q;
  assign flush          = flush_q;
  assign redirect_valid = redir_v_q;
  assign redirect_pc    = redir_pc_q;
  assign pend_cnt       = cnt_q;
  assign err            = err_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: prediction, training, queue limits,
// mispredict flush/redirect timeline, err flag and asynchronous reset.
module tb_branch_pred_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pred_req = 1'b0;
  logic [15:0] pred_pc = '0;
  logic [15:0] pred_target = '0;
  logic [1:0]  pred_type = 2'b00;
  logic        pred_taken, pred_ack, last_pred;
  logic [1:0]  last_type;
  logic        chk_checked = 1'b0, chk_incorrect = 1'b0, chk_correct = 1'b0;
  logic        flush, redirect_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  pend_cnt;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  branch_pred_ctrl #(.IDX_W(4), .PC_W(16), .FLUSH_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_type(pred_type), .pred_taken(pred_taken),
    .pred_ack(pred_ack), .last_pred(last_pred), .last_type(last_type),
    .chk_checked(chk_checked), .chk_incorrect(chk_incorrect), .chk_correct(chk_correct),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [15:0] tgt, input logic [1:0] typ,
                      input logic exp_taken, input logic exp_ack, input string tag);
    pred_req = 1'b1; pred_pc = pc; pred_target = tgt; pred_type = typ;
    #1;
    check_eq({tag, " taken"}, pred_taken, exp_taken);
    check_eq({tag, " ack"}, pred_ack, exp_ack);
    tick();
    pred_req = 1'b0; pred_type = 2'b00;
  endtask

  task automatic resolve(input logic c, input int hold);
    chk_checked = 1'b1; chk_correct = c; chk_incorrect = 1'b0;
    repeat (hold) tick();
    chk_checked = 1'b0; chk_correct = 1'b0;
    tick();
  endtask

  task automatic mispredict(input logic c, input logic [15:0] exp_pc, input string tag);
    pred_req = 1'b1; pred_type = 2'b01; pred_pc = 16'h0AAA; pred_target = 16'h0BBB;
    chk_checked = 1'b1; chk_incorrect = 1'b1; chk_correct = c;
    #1;
    check_eq({tag, " ack at event"}, pred_ack, 0);
    tick();
    check_eq({tag, " flush c1"}, flush, 1);
    check_eq({tag, " rv c1"}, redirect_valid, 0);
    check_eq({tag, " pend c1"}, pend_cnt, 0);
    check_eq({tag, " ack c1"}, pred_ack, 0);
    chk_checked = 1'b0; chk_incorrect = 1'b0;
    tick();
    check_eq({tag, " flush c2"}, flush, 1);
    check_eq({tag, " ack c2"}, pred_ack, 0);
    chk_checked = 1'b1;
    tick();
    check_eq({tag, " flush redir"}, flush, 0);
    check_eq({tag, " rv redir"}, redirect_valid, 1);
    check_eq({tag, " redirect_pc"}, redirect_pc, exp_pc);
    check_eq({tag, " ack redir"}, pred_ack, 0);
    check_eq({tag, " err ignored"}, err, 0);
    chk_checked = 1'b0;
    tick();
    check_eq({tag, " rv idle"}, redirect_valid, 0);
    check_eq({tag, " pend idle"}, pend_cnt, 0);
    check_eq({tag, " ack idle"}, pred_ack, 1);
    pred_req = 1'b0; pred_type = 2'b00;
    chk_correct = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst pend", pend_cnt, 0);
    check_eq("rst flush", flush, 0);
    check_eq("rst rv", redirect_valid, 0);
    check_eq("rst rpc", redirect_pc, 0);
    check_eq("rst last_pred", last_pred, 0);
    check_eq("rst last_type", last_type, 0);
    check_eq("rst err", err, 0);
    rst_n = 1'b1;
    tick();

    // Basic prediction from reset counters
    push(16'h0013, 16'h0100, 2'b10, 0, 1, "jne13");
    check_eq("jne13 last_pred", last_pred, 0);
    check_eq("jne13 last_type", last_type, 2);
    check_eq("jne13 pend", pend_cnt, 1);

    // Held checked level is one event: one pop, no err
    resolve(1, 3);
    check_eq("edge pend", pend_cnt, 0);
    check_eq("edge err", err, 0);
    push(16'h0003, 16'h0200, 2'b10, 1, 1, "jne03 trained");
    check_eq("jne03 last_pred", last_pred, 1);
    resolve(1, 1);

    // Saturation: 4 taken resolutions on index 3
    push(16'h0013, 16'h0100, 2'b10, 1, 1, "sat3");
    resolve(1, 1);
    push(16'h0013, 16'h0100, 2'b10, 1, 1, "sat4");
    resolve(1, 1);
    push(16'h0023, 16'h0500, 2'b10, 1, 1, "sat pred");
    mispredict(0, 16'h0024, "mp_nt");
    push(16'h0003, 16'h0200, 2'b10, 1, 1, "no wrap");
    resolve(1, 1);

    // Full queue then mispredict with taken target
    push(16'h0020, 16'h0040, 2'b10, 0, 1, "mp jne20");
    push(16'h0050, 16'h0060, 2'b01, 1, 1, "mp jmp50");
    check_eq("full pend", pend_cnt, 2);
    check_eq("full last_type", last_type, 1);
    push(16'h0070, 16'h0080, 2'b10, 0, 0, "third req");
    check_eq("full pend kept", pend_cnt, 2);
    mispredict(1, 16'h0040, "mp_t");
    push(16'h0020, 16'h0040, 2'b10, 1, 1, "c0 trained");
    resolve(1, 1);

    // Simultaneous push and pop keeps order
    push(16'h0005, 16'h0111, 2'b10, 0, 1, "simA");
    pred_req = 1'b1; pred_type = 2'b01; pred_pc = 16'h0007; pred_target = 16'h0222;
    chk_checked = 1'b1; chk_correct = 1'b0; chk_incorrect = 1'b0;
    #1;
    check_eq("simB ack", pred_ack, 1);
    tick();
    check_eq("sim pend", pend_cnt, 1);
    check_eq("sim last_type", last_type, 1);
    pred_req = 1'b0; pred_type = 2'b00; chk_checked = 1'b0;
    tick();
    mispredict(1, 16'h0222, "mp_order");

    // pc+1 wraps modulo 2^16
    push(16'hFFFF, 16'h1234, 2'b10, 0, 1, "wrap");
    mispredict(0, 16'h0000, "mp_wrap");

    // Event on empty queue sets sticky err
    resolve(1, 2);
    check_eq("err set", err, 1);
    repeat (3) tick();
    check_eq("err sticky", err, 1);
    check_eq("err pend", pend_cnt, 0);

    // Asynchronous reset in the middle of FLUSH
    push(16'h0043, 16'h0300, 2'b10, 1, 1, "pre rst");
    chk_checked = 1'b1; chk_incorrect = 1'b1; chk_correct = 1'b0;
    tick();
    check_eq("mid flush", flush, 1);
    chk_checked = 1'b0; chk_incorrect = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("async flush", flush, 0);
    check_eq("async rv", redirect_valid, 0);
    check_eq("async err", err, 0);
    check_eq("async last_pred", last_pred, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post rst pend", pend_cnt, 0);
    push(16'h0003, 16'h0200, 2'b10, 0, 1, "c3 reinit");
    push(16'h0020, 16'h0040, 2'b10, 0, 1, "c0 reinit");
    check_eq("post rst pend2", pend_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
